// File: rtl/ahb_sub_pkg.sv
// rtl/ahb_sub_pkg.sv - shared AHB-Lite types and constants for the register bank
package ahb_sub_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahb_lite_sub_regbank_if.sv
// rtl/ahb_lite_sub_regbank_if.sv - AHB-Lite subordinate bus bundle with master/slave views
interface ahb_lite_sub_regbank_if
  import ahb_sub_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic                HSEL;
  logic [31:0]         HADDR;
  htrans_t             HTRANS;
  logic [2:0]          HSIZE;
  logic                HWRITE;
  logic [DATA_W-1:0]   HWDATA;
  logic [DATA_W/8-1:0] HWSTRB;
  logic                HREADY;
  logic [2:0]          HBURST;
  logic [6:0]          HPROT;
  logic                HMASTLOCK;
  logic [DATA_W-1:0]   HRDATA;
  logic                HREADYOUT;
  logic                HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HWSTRB, HREADY,
           HBURST, HPROT, HMASTLOCK,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HWSTRB, HREADY,
           HBURST, HPROT, HMASTLOCK,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sub_bytemask.sv
// rtl/ahb_sub_bytemask.sv - byte-lane write mask from size/address; ANDed with strobes under AHB_SUB_WSTRB_EN
module ahb_sub_bytemask #(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int AW     = $clog2(NB)
) (
  input  logic [2:0]    size,
  input  logic [AW-1:0] addr_lo,
  input  logic [NB-1:0] strb,
  output logic [NB-1:0] mask
);

  logic [NB-1:0] lane;

  // Lanes covered by a naturally aligned transfer of 2**size bytes at addr_lo.
  always_comb begin
    lane = '0;
    for (int i = 0; i < NB; i++) begin
      if (i >= int'(addr_lo) && i < int'(addr_lo) + (1 << size)) begin
        lane[i] = 1'b1;
      end
    end
  end

`ifdef AHB_SUB_WSTRB_EN
  assign mask = lane & strb;
`else
  logic unused_strb;
  assign unused_strb = ^strb;
  assign mask = lane;
`endif

endmodule

// File: rtl/ahb_lite_sub_regbank.sv
// rtl/ahb_lite_sub_regbank.sv - AHB-Lite RW register bank with wait states and two-cycle ERROR
// Optional strobe gating of write lanes: AHB_SUB_WSTRB_EN.
module ahb_lite_sub_regbank
  import ahb_sub_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                NREG        = 8,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  ahb_lite_sub_regbank_if.slave  bus,
  output logic [NREG*DATA_W-1:0] regs_o,
  output logic [NREG-1:0]        wr_pulse_o
);

  localparam int NB    = DATA_W / 8;
  localparam int AW    = $clog2(NB);
  localparam int IDX_W = $clog2(NREG);

  state_t            state, next_state, nxt_xfer;
  logic [1:0]        wait_cnt;
  logic              last_cyc, accept, take, addr_err, commit;
  logic [31:0]       word_idx;
  logic [AW-1:0]     lo_mask;
  logic              d_write;
  logic [IDX_W-1:0]  d_idx;
  logic [2:0]        d_size;
  logic [AW-1:0]     d_lo;
  logic [NB-1:0]     lane_mask;
  logic [DATA_W-1:0] regs [NREG];

  logic unused_ok;
  assign unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK};

  // Address-phase decode and error classification.
  assign accept   = bus.HSEL && bus.HREADY &&
                    (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);
  assign word_idx = bus.HADDR >> AW;
  assign lo_mask  = AW'((32'd1 << bus.HSIZE) - 32'd1);
  assign addr_err = (bus.HSIZE > 3'(AW)) ||
                    (|(bus.HADDR[AW-1:0] & lo_mask)) ||
                    (word_idx >= 32'(NREG));

  assign last_cyc = (state == ST_WAIT) && (wait_cnt == 2'(WAIT_STATES));
  // A new address phase is only sampled when this slave is not stalling the bus.
  assign take     = accept && (state == ST_IDLE || state == ST_ERR2 || last_cyc);
  assign commit   = last_cyc && d_write;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    nxt_xfer   = take ? (addr_err ? ST_ERR1 : ST_WAIT) : ST_IDLE;
    next_state = state;
    case (state)
      ST_IDLE: next_state = nxt_xfer;
      ST_WAIT: next_state = last_cyc ? nxt_xfer : ST_WAIT;
      ST_ERR1: next_state = ST_ERR2;
      ST_ERR2: next_state = nxt_xfer;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = HRESP_OKAY;
    bus.HRDATA    = '0;
    case (state)
      ST_WAIT: begin
        bus.HREADYOUT = last_cyc;
        if (!d_write) bus.HRDATA = regs[d_idx];
      end
      ST_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = HRESP_ERROR;
      end
      ST_ERR2: bus.HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn)                      wait_cnt <= '0;
    else if (state == ST_WAIT && !last_cyc) wait_cnt <= wait_cnt + 2'd1;
    else                               wait_cnt <= '0;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      d_write <= 1'b0;
      d_idx   <= '0;
      d_size  <= '0;
      d_lo    <= '0;
    end else if (take) begin
      d_write <= bus.HWRITE;
      d_idx   <= word_idx[IDX_W-1:0];
      d_size  <= bus.HSIZE;
      d_lo    <= bus.HADDR[AW-1:0];
    end
  end

  ahb_sub_bytemask #(.DATA_W(DATA_W)) u_bytemask (
    .size    (d_size),
    .addr_lo (d_lo),
    .strb    (bus.HWSTRB),
    .mask    (lane_mask)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int k = 0; k < NREG; k++) regs[k] <= RESET_VAL;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (commit) begin
        wr_pulse_o[d_idx] <= 1'b1;
        for (int b = 0; b < NB; b++) begin
          if (lane_mask[b]) regs[d_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
        end
      end
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_flat
    assign regs_o[k*DATA_W +: DATA_W] = regs[k];
  end

endmodule

// File: tb/tb_ahb_lite_sub_regbank.sv
// tb/tb_ahb_lite_sub_regbank.sv - directed bench: unit 0 zero-wait bank, unit 1 two-wait bank
module tb_ahb_lite_sub_regbank;
  import ahb_sub_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn0, rstn1;
  logic hsel [2];
  logic [31:0] haddr [2];
  htrans_t htrans [2];
  logic [2:0] hsize [2];
  logic hwrite [2];
  logic [31:0] hwdata [2];
  logic [3:0] hwstrb [2];
  logic [255:0] regs0, regs1;
  logic [7:0] pulse0, pulse1;
  int checks = 0;
  int failures = 0;

  ahb_lite_sub_regbank_if #(.DATA_W(32)) bus0 ();
  ahb_lite_sub_regbank_if #(.DATA_W(32)) bus1 ();

  assign bus0.HSEL = hsel[0];   assign bus1.HSEL = hsel[1];
  assign bus0.HADDR = haddr[0]; assign bus1.HADDR = haddr[1];
  assign bus0.HTRANS = htrans[0]; assign bus1.HTRANS = htrans[1];
  assign bus0.HSIZE = hsize[0]; assign bus1.HSIZE = hsize[1];
  assign bus0.HWRITE = hwrite[0]; assign bus1.HWRITE = hwrite[1];
  assign bus0.HWDATA = hwdata[0]; assign bus1.HWDATA = hwdata[1];
  assign bus0.HWSTRB = hwstrb[0]; assign bus1.HWSTRB = hwstrb[1];
  assign bus0.HREADY = bus0.HREADYOUT; assign bus1.HREADY = bus1.HREADYOUT;
  assign bus0.HBURST = 3'd0; assign bus1.HBURST = 3'd0;
  assign bus0.HPROT = 7'd0;  assign bus1.HPROT = 7'd0;
  assign bus0.HMASTLOCK = 1'b0; assign bus1.HMASTLOCK = 1'b0;

  ahb_lite_sub_regbank #(.DATA_W(32), .NREG(8), .WAIT_STATES(0), .RESET_VAL(32'h0)) dut0 (
    .HCLK(clk), .HRESETn(rstn0), .bus(bus0), .regs_o(regs0), .wr_pulse_o(pulse0));
  ahb_lite_sub_regbank #(.DATA_W(32), .NREG(8), .WAIT_STATES(2), .RESET_VAL(32'hCAFEF00D)) dut1 (
    .HCLK(clk), .HRESETn(rstn1), .bus(bus1), .regs_o(regs1), .wr_pulse_o(pulse1));

  function automatic logic rdy(input int u);
    return (u == 0) ? bus0.HREADYOUT : bus1.HREADYOUT;
  endfunction
  function automatic logic rsp(input int u);
    return (u == 0) ? bus0.HRESP : bus1.HRESP;
  endfunction
  function automatic logic [31:0] rdat(input int u);
    return (u == 0) ? bus0.HRDATA : bus1.HRDATA;
  endfunction
  function automatic logic [31:0] reg_of(input int u, input int k);
    return (u == 0) ? regs0[k*32 +: 32] : regs1[k*32 +: 32];
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic ap(input int u, input logic [31:0] a, input logic [2:0] s, input logic w);
    hsel[u] = 1'b1; haddr[u] = a; htrans[u] = HTRANS_NONSEQ; hsize[u] = s; hwrite[u] = w;
  endtask

  task automatic no_ap(input int u);
    hsel[u] = 1'b0; haddr[u] = 32'h0; htrans[u] = HTRANS_IDLE; hsize[u] = 3'd0; hwrite[u] = 1'b0;
  endtask

  task automatic wait_ready(input int u, output logic [31:0] rd, output logic resp);
    int n;
    n = 0;
    @(negedge clk);
    while (rdy(u) !== 1'b1 && n < 8) begin n++; @(negedge clk); end
    checks++;
    if (rdy(u) !== 1'b1) begin failures++; $display("FAIL ready_timeout unit=%0d got=%b want=1", u, rdy(u)); end
    rd = rdat(u); resp = rsp(u);
    step();
  endtask

  task automatic xfer(input int u, input logic [31:0] a, input logic [2:0] s, input logic w,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output logic resp);
    ap(u, a, s, w);
    step();
    no_ap(u);
    hwdata[u] = wd; hwstrb[u] = st;
    wait_ready(u, rd, resp);
  endtask

  task automatic test_reset();
    logic [255:0] exp1;
    exp1 = {8{32'hCAFEF00D}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (rdy(0) !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", rdy(0)); end
    checks++; if (rsp(0) !== 1'b0) begin failures++; $display("FAIL rst_resp got=%b want=0", rsp(0)); end
    checks++; if (rdat(0) !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h want=0", rdat(0)); end
    checks++; if (pulse0 !== 8'h0) begin failures++; $display("FAIL rst_pulse got=%h want=0", pulse0); end
    checks++; if (regs0 !== 256'h0) begin failures++; $display("FAIL rst_regs0 got=%h want=0", regs0); end
    checks++; if (regs1 !== exp1) begin failures++; $display("FAIL rst_regs1 got=%h want=%h", regs1, exp1); end
    checks++; if (rdy(1) !== 1'b1) begin failures++; $display("FAIL rst_ready1 got=%b want=1", rdy(1)); end
    rstn0 = 1'b1; rstn1 = 1'b1;
    step();
  endtask

  task automatic test_word_write();
    logic [31:0] rd; logic resp;
    xfer(0, 32'h04, HSIZE_WORD, 1'b1, 32'hDEADBEEF, 4'hF, rd, resp);
    checks++; if (resp !== HRESP_OKAY) begin failures++; $display("FAIL ww_resp got=%b want=0", resp); end
    @(negedge clk);
    checks++; if (pulse0 !== 8'h02) begin failures++; $display("FAIL ww_pulse got=%h want=02", pulse0); end
    checks++; if (reg_of(0, 1) !== 32'hDEADBEEF) begin failures++; $display("FAIL ww_reg got=%h want=deadbeef", reg_of(0, 1)); end
    step(); @(negedge clk);
    checks++; if (pulse0 !== 8'h00) begin failures++; $display("FAIL ww_pulse_once got=%h want=00", pulse0); end
    xfer(0, 32'h04, HSIZE_WORD, 1'b0, 32'h0, 4'hF, rd, resp);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL ww_read got=%h want=deadbeef", rd); end
    checks++; if (resp !== HRESP_OKAY) begin failures++; $display("FAIL ww_read_resp got=%b want=0", resp); end
    @(negedge clk);
    checks++; if (pulse0 !== 8'h00) begin failures++; $display("FAIL rd_no_pulse got=%h want=00", pulse0); end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic resp;
    xfer(0, 32'h04, HSIZE_WORD, 1'b1, 32'h11223344, 4'hF, rd, resp);
    xfer(0, 32'h06, HSIZE_HALF, 1'b1, 32'hABCD0000, 4'hF, rd, resp);
    xfer(0, 32'h04, HSIZE_WORD, 1'b0, 32'h0, 4'hF, rd, resp);
    checks++; if (rd !== 32'hABCD3344) begin failures++; $display("FAIL half_read got=%h want=abcd3344", rd); end
    xfer(0, 32'h07, HSIZE_BYTE, 1'b1, 32'hEE000000, 4'hF, rd, resp);
    xfer(0, 32'h09, HSIZE_BYTE, 1'b1, 32'h00005A00, 4'hF, rd, resp);
    @(negedge clk);
    checks++; if (reg_of(0, 1) !== 32'hEECD3344) begin failures++; $display("FAIL byte3_reg got=%h want=eecd3344", reg_of(0, 1)); end
    checks++; if (reg_of(0, 2) !== 32'h00005A00) begin failures++; $display("FAIL byte1_reg got=%h want=00005a00", reg_of(0, 2)); end
  endtask

  task automatic test_errors();
    logic [255:0] exp; logic [31:0] rd; logic resp;
    logic [31:0] bad_a [3];
    logic [2:0] bad_s [3];
    exp = '0; exp[32 +: 32] = 32'hEECD3344; exp[64 +: 32] = 32'h00005A00;
    bad_a[0] = 32'h02; bad_s[0] = HSIZE_WORD;
    bad_a[1] = 32'h05; bad_s[1] = HSIZE_HALF;
    bad_a[2] = 32'h00; bad_s[2] = HSIZE_DWORD;
    step();
    ap(0, 32'h20, HSIZE_WORD, 1'b1); step(); no_ap(0); hwdata[0] = 32'hFFFFFFFF;
    @(negedge clk);
    checks++; if (rdy(0) !== 1'b0) begin failures++; $display("FAIL err1_ready got=%b want=0", rdy(0)); end
    checks++; if (rsp(0) !== 1'b1) begin failures++; $display("FAIL err1_resp got=%b want=1", rsp(0)); end
    step(); @(negedge clk);
    checks++; if (rdy(0) !== 1'b1) begin failures++; $display("FAIL err2_ready got=%b want=1", rdy(0)); end
    checks++; if (rsp(0) !== 1'b1) begin failures++; $display("FAIL err2_resp got=%b want=1", rsp(0)); end
    step(); @(negedge clk);
    checks++; if (rsp(0) !== 1'b0) begin failures++; $display("FAIL err_done_resp got=%b want=0", rsp(0)); end
    checks++; if (pulse0 !== 8'h00) begin failures++; $display("FAIL err_pulse got=%h want=00", pulse0); end
    for (int i = 0; i < 3; i++) begin
      xfer(0, bad_a[i], bad_s[i], 1'b1, 32'hFFFFFFFF, 4'hF, rd, resp);
      checks++; if (resp !== HRESP_ERROR) begin failures++; $display("FAIL err_case%0d_resp got=%b want=1", i, resp); end
    end
    xfer(0, 32'h24, HSIZE_WORD, 1'b0, 32'h0, 4'hF, rd, resp);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL err_read_data got=%h want=0", rd); end
    @(negedge clk);
    checks++; if (regs0 !== exp) begin failures++; $display("FAIL err_regs got=%h want=%h", regs0, exp); end
  endtask

  task automatic test_back_to_back();
    step();
    hsel[0] = 1'b1; haddr[0] = 32'h40; htrans[0] = HTRANS_BUSY; hsize[0] = HSIZE_WORD;
    step(); no_ap(0); @(negedge clk);
    checks++; if (rdy(0) !== 1'b1 || rsp(0) !== 1'b0) begin failures++; $display("FAIL busy_resp got=%b%b want=10", rdy(0), rsp(0)); end
    step();
    ap(0, 32'h0C, HSIZE_WORD, 1'b1); step();
    hwdata[0] = 32'h13579BDF; ap(0, 32'h0C, HSIZE_WORD, 1'b0); htrans[0] = HTRANS_SEQ;
    @(negedge clk);
    checks++; if (rdy(0) !== 1'b1) begin failures++; $display("FAIL b2b_wr_ready got=%b want=1", rdy(0)); end
    step(); no_ap(0); @(negedge clk);
    checks++; if (rdat(0) !== 32'h13579BDF) begin failures++; $display("FAIL b2b_rd_data got=%h want=13579bdf", rdat(0)); end
    checks++; if (pulse0 !== 8'h08) begin failures++; $display("FAIL b2b_pulse got=%h want=08", pulse0); end
    step(); @(negedge clk);
    checks++; if (rdat(0) !== 32'h0) begin failures++; $display("FAIL idle_rdata got=%h want=0", rdat(0)); end
    step();
    ap(0, 32'h40, HSIZE_WORD, 1'b1); step(); no_ap(0);
    @(negedge clk); step();
    ap(0, 32'h0C, HSIZE_WORD, 1'b0);
    @(negedge clk);
    checks++; if (rsp(0) !== 1'b1 || rdy(0) !== 1'b1) begin failures++; $display("FAIL err2_accept_phase got=%b%b want=11", rsp(0), rdy(0)); end
    step(); no_ap(0); @(negedge clk);
    checks++; if (rsp(0) !== 1'b0 || rdat(0) !== 32'h13579BDF) begin failures++; $display("FAIL err2_accept_read got=%b %h want=0 13579bdf", rsp(0), rdat(0)); end
    step();
  endtask

  task automatic test_wait_states();
    logic [2:0] pat; logic [31:0] rd; logic resp;
    ap(1, 32'h04, HSIZE_WORD, 1'b0); step(); no_ap(1);
    @(negedge clk); pat[2] = rdy(1);
    checks++; if (rdat(1) !== 32'hCAFEF00D) begin failures++; $display("FAIL ws_rdata_early got=%h want=cafef00d", rdat(1)); end
    step(); @(negedge clk); pat[1] = rdy(1);
    step(); ap(1, 32'h08, HSIZE_WORD, 1'b0); @(negedge clk); pat[0] = rdy(1);
    step(); no_ap(1);
    checks++; if (pat !== 3'b001) begin failures++; $display("FAIL ws_ready_seq1 got=%b want=001", pat); end
    @(negedge clk); pat[2] = rdy(1);
    step(); @(negedge clk); pat[1] = rdy(1);
    step(); @(negedge clk); pat[0] = rdy(1);
    checks++; if (rdat(1) !== 32'hCAFEF00D) begin failures++; $display("FAIL ws_rdata_b2b got=%h want=cafef00d", rdat(1)); end
    step();
    checks++; if (pat !== 3'b001) begin failures++; $display("FAIL ws_ready_seq2 got=%b want=001", pat); end
    xfer(1, 32'h10, HSIZE_WORD, 1'b1, 32'h12345678, 4'hF, rd, resp);
    @(negedge clk);
    checks++; if (reg_of(1, 4) !== 32'h12345678) begin failures++; $display("FAIL ws_write got=%h want=12345678", reg_of(1, 4)); end
    checks++; if (pulse1 !== 8'h10) begin failures++; $display("FAIL ws_pulse got=%h want=10", pulse1); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [7:0] seen;
    ap(1, 32'h14, HSIZE_WORD, 1'b1); step(); no_ap(1); hwdata[1] = 32'h0BADC0DE;
    @(negedge clk);
    checks++; if (rdy(1) !== 1'b0) begin failures++; $display("FAIL mid_wait_ready got=%b want=0", rdy(1)); end
    rstn1 = 1'b0; step(); rstn1 = 1'b1;
    @(negedge clk);
    checks++; if (rdy(1) !== 1'b1 || rsp(1) !== 1'b0) begin failures++; $display("FAIL mid_rst_out got=%b%b want=10", rdy(1), rsp(1)); end
    seen = pulse1;
    for (int i = 0; i < 4; i++) begin step(); @(negedge clk); seen = seen | pulse1; end
    checks++; if (seen !== 8'h00) begin failures++; $display("FAIL mid_rst_pulse got=%h want=00", seen); end
    checks++; if (reg_of(1, 5) !== 32'hCAFEF00D) begin failures++; $display("FAIL mid_rst_reg5 got=%h want=cafef00d", reg_of(1, 5)); end
    checks++; if (reg_of(1, 4) !== 32'hCAFEF00D) begin failures++; $display("FAIL mid_rst_reg4 got=%h want=cafef00d", reg_of(1, 4)); end
  endtask

  task automatic test_wstrb();
    logic [31:0] rd; logic resp; logic [31:0] exp5, exp6;
`ifdef AHB_SUB_WSTRB_EN
    exp5 = 32'h00FF00FF; exp6 = 32'h00AA0000;
`else
    exp5 = 32'hFFFFFFFF; exp6 = 32'hAAAA0000;
`endif
    step();
    xfer(0, 32'h14, HSIZE_WORD, 1'b1, 32'hFFFFFFFF, 4'b0101, rd, resp);
    xfer(0, 32'h1A, HSIZE_HALF, 1'b1, 32'hAAAAAAAA, 4'b0100, rd, resp);
    @(negedge clk);
    checks++; if (reg_of(0, 5) !== exp5) begin failures++; $display("FAIL wstrb_word got=%h want=%h", reg_of(0, 5), exp5); end
    checks++; if (reg_of(0, 6) !== exp6) begin failures++; $display("FAIL wstrb_half got=%h want=%h", reg_of(0, 6), exp6); end
  endtask

  initial begin
    rstn0 = 1'b0; rstn1 = 1'b0;
    for (int u = 0; u < 2; u++) begin
      no_ap(u); hwdata[u] = 32'h0; hwstrb[u] = 4'hF;
    end
    test_reset();
    test_word_write();
    test_subword();
    test_errors();
    test_back_to_back();
    test_wait_states();
    test_reset_mid();
    test_wstrb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_lite_sub_regbank.md
AHB_LITE_SUB_REGBANK -- requirements
Module: ahb_lite_sub_regbank

Interface
REQ-001 Parameter: DATA_W, default 32, bus data width (32 or 64).
REQ-002 Parameter: NREG, default 8, number of RW registers (power of two, 2..64).
REQ-003 Parameter: WAIT_STATES, default 0, HREADYOUT-low cycles per OKAY transfer (0..3).
REQ-004 Parameter: RESET_VAL, default 0, reset value of every register (DATA_W bits).
REQ-005 Port: HCLK  in  1  single clock; every flop SHALL be clocked by its rising edge.
REQ-006 Port: HRESETn  in  1  reset; synchronous, active-low.
REQ-007 Ports, all in: HSEL 1 (select); HADDR 32 (address); HTRANS 2 (transfer type); HSIZE 3 (transfer size); HWRITE 1 (write/read); HWDATA DATA_W (write data); HWSTRB DATA_W/8 (byte strobes); HREADY 1 (bus ready).
REQ-008 Ports, all in, accepted and ignored: HBURST 3; HPROT 7; HMASTLOCK 1.
REQ-009 Ports, all out: HRDATA DATA_W (read data); HREADYOUT 1 (ready); HRESP 1 (0 = OKAY, 1 = ERROR).
REQ-010 Port: regs_o  out  NREG*DATA_W  flat register contents, reg k at bits [k*DATA_W +: DATA_W].
REQ-011 Port: wr_pulse_o  out  NREG  one-cycle pulse per register on a committed write.

Function
REQ-012 Address phase SHALL be accepted only when HSEL=1, HREADY=1 and HTRANS is NONSEQ (2) or SEQ (3); the control signals SHALL be registered then.
REQ-013 IDLE or BUSY transfers, or HSEL=0, SHALL get a zero-wait OKAY response (HREADYOUT=1, HRESP=0).
REQ-014 The FSM SHALL have four states: IDLE, WAIT, ERR1, ERR2.
REQ-015 Valid transfer with WAIT_STATES>0: IDLE -> WAIT; stay in WAIT with HREADYOUT=0 for WAIT_STATES cycles; then HREADYOUT=1 in the final cycle.
REQ-016 Valid transfer with WAIT_STATES=0: the data phase SHALL be one cycle, HREADYOUT=1.
REQ-017 Back-to-back transfers SHALL be pipelined: a new address phase accepted in the final data-phase cycle starts its own data phase next cycle, with no bubble.
REQ-018 A transfer is an error if any of these holds:
- HSIZE > log2(DATA_W/8);
- HADDR not aligned to HSIZE;
- word index HADDR[..] >= NREG.
REQ-019 Error response is two cycles: ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE or the next accepted transfer.
REQ-020 An address phase presented during ERR2 with HREADY=1 SHALL be accepted.
REQ-021 An errored write SHALL modify no register and pulse no wr_pulse_o bit.
REQ-022 Write commit: in the final data-phase cycle, the bytes selected by the lane mask SHALL be loaded from HWDATA at the next edge, and wr_pulse_o[idx] SHALL be high for that one cycle.
REQ-023 The lane mask SHALL be derived from HSIZE and the registered HADDR low bits; byte lanes outside the mask SHALL be unchanged.
REQ-024 HRDATA SHALL carry the full addressed register during every data-phase cycle of a valid read, and 0 otherwise.
REQ-025 A read immediately following a write to the same address SHALL return the newly written data.

Reset
REQ-026 While HRESETn=0 at a rising edge, the following SHALL take their reset values:
- FSM -> IDLE and wait counter -> 0;
- all registers -> RESET_VAL;
- HREADYOUT -> 1, HRESP -> 0, HRDATA -> 0, wr_pulse_o -> 0.
REQ-027 Reset asserted mid-transfer (WAIT/ERR1/ERR2) SHALL abort it with no register write.

Configuration
REQ-028 Macro AHB_SUB_WSTRB_EN defined: lane mask SHALL be the REQ-023 mask AND HWSTRB (sampled in the data phase).
REQ-029 Macro AHB_SUB_WSTRB_EN undefined: HWSTRB SHALL be ignored and the mask SHALL come from HSIZE/HADDR only.

Structure
REQ-030 Package ahb_sub_pkg SHALL hold the following, and no other file SHALL redefine them:
- htrans_t enum (IDLE/BUSY/NONSEQ/SEQ);
- hresp constants (OKAY/ERROR);
- hsize constants;
- FSM state enum.
REQ-031 Byte-lane mask generation SHALL be one combinational sub-module, ahb_sub_bytemask (inputs: size, addr low bits, strobes; output: mask).

Verification
REQ-032 Word write, WAIT_STATES=0: write 0xDEADBEEF to 0x04, then read 0x04 -> HRDATA=0xDEADBEEF, HRESP=0, wr_pulse_o[1] pulsed once.
REQ-033 Halfword write: write HSIZE=1 to 0x06 with HWDATA=0xABCD0000 over a register holding 0x11223344 -> register reads 0xABCD3344.
REQ-034 Out-of-range write: write to 0x20 with NREG=8 -> ERR1 then ERR2 cycles (HREADYOUT 0 then 1, HRESP=1 both), no register change.
REQ-035 WAIT_STATES=2 read: HREADYOUT = 0,0,1 over the data phase; back-to-back read to 0x08 starts the cycle after.
REQ-036 Reset mid-transfer: HRESETn=0 during WAIT of a write -> register keeps RESET_VAL, HREADYOUT=1 next cycle.
REQ-037 With AHB_SUB_WSTRB_EN: word write of 0xFFFFFFFF with HWSTRB=0b0101 over 0 -> register reads 0x00FF00FF.
